controller_sequencer: RTL and testbench

//  SAP-1 controller/sequencer. A 6-state one-hot ring counter (T1..T6) steps fetch and execute.
//  It decodes the instruction register's opcode nibble into the 12-bit control word that drives
//  PC, MAR, RAM, IR, accumulator, ALU, B and output registers. On HLT it stops the ring.

---
 rtl/sap1_pkg.sv | 39 +++
 rtl/controller_sequencer_ring_counter.sv | 37 +++
 rtl/controller_sequencer.sv | 93 +++++++++
 tb/tb_controller_sequencer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// SAP-1 controller constants: opcodes, control-word bit positions, idle word, T-state codes.
// Latency: n/a (package). Backpressure: n/a.
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Bit positions within con = {Cp,Ep,nLm,nCE,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}
    localparam int CB_CP  = 11;
    localparam int CB_EP  = 10;
    localparam int CB_NLM = 9;
    localparam int CB_NCE = 8;
    localparam int CB_NLI = 7;
    localparam int CB_NEI = 6;
    localparam int CB_NLA = 5;
    localparam int CB_EA  = 4;
    localparam int CB_SU  = 3;
    localparam int CB_EU  = 2;
    localparam int CB_NLB = 1;
    localparam int CB_NLO = 0;

    localparam logic [11:0] CON_IDLE = 12'h3E3;

    localparam logic [5:0] TS_T1 = 6'b000001;
    localparam logic [5:0] TS_T2 = 6'b000010;
    localparam logic [5:0] TS_T3 = 6'b000100;
    localparam logic [5:0] TS_T4 = 6'b001000;
    localparam logic [5:0] TS_T5 = 6'b010000;
    localparam logic [5:0] TS_T6 = 6'b100000;

    function automatic logic is_nop(input logic [3:0] op);
        return !(op == OP_LDA || op == OP_ADD || op == OP_SUB ||
                 op == OP_OUT || op == OP_HLT);
    endfunction

endpackage

// File: rtl/controller_sequencer_ring_counter.sv
// One-hot T1..T6 ring with hold and early-restart; illegal codes fall back to T1.
// Latency: state updates on each CLK edge. Backpressure: hold freezes the ring.
module ring_counter
    import sap1_pkg::*;
(
    input  logic       CLK,
    input  logic       CLR,
    input  logic       hold,
    input  logic       restart,
    output logic [5:0] t_state
);

    logic [5:0] state_q;
    logic [5:0] state_d;

    always_comb begin
        state_d = {state_q[4:0], state_q[5]};
        if (!$onehot(state_q)) begin
            state_d = TS_T1;
        end else if (hold) begin
            state_d = state_q;
        end else if (restart) begin
            state_d = TS_T1;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= TS_T1;
        end else begin
            state_q <= state_d;
        end
    end

    assign t_state = state_q;

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller/sequencer: decodes T-state and opcode into the 12-bit control word, handles HLT.
// Latency: con is combinational; t_state/hlt update per CLK. Backpressure: HLT freezes the ring.
module controller_sequencer
    import sap1_pkg::*;
#(
    parameter bit EARLY_END = 1'b0,
    parameter int CW_WIDTH  = 12
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic [3:0]          opcode,
    output logic [CW_WIDTH-1:0] con,
    output logic [5:0]          t_state,
    output logic                hlt
);

    logic                hlt_q;
    logic                hlt_d;
    logic                halt_now;
    logic                last_state;
    logic [CW_WIDTH-1:0] con_w;

    ring_counter u_ring (
        .CLK     (CLK),
        .CLR     (CLR),
        .hold    (hlt_q | halt_now),
        .restart (EARLY_END & last_state),
        .t_state (t_state)
    );

    assign halt_now = !hlt_q && (t_state == TS_T4) && (opcode == OP_HLT);
    assign hlt_d    = hlt_q | halt_now;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            hlt_q <= 1'b0;
        end else begin
            hlt_q <= hlt_d;
        end
    end

    // Idle word while in reset or halted so nothing loads or drives the bus.
    always_comb begin
        con_w = CON_IDLE;
        if (!CLR && !hlt_q) begin
            case (t_state)
                TS_T1: begin con_w[CB_EP] = 1'b1; con_w[CB_NLM] = 1'b0; end
                TS_T2: begin con_w[CB_CP] = 1'b1; end
                TS_T3: begin con_w[CB_NCE] = 1'b0; con_w[CB_NLI] = 1'b0; end
                TS_T4: begin
                    if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                        con_w[CB_NEI] = 1'b0;
                        con_w[CB_NLM] = 1'b0;
                    end else if (opcode == OP_OUT) begin
                        con_w[CB_EA]  = 1'b1;
                        con_w[CB_NLO] = 1'b0;
                    end
                end
                TS_T5: begin
                    if (opcode == OP_LDA) begin
                        con_w[CB_NCE] = 1'b0;
                        con_w[CB_NLA] = 1'b0;
                    end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                        con_w[CB_NCE] = 1'b0;
                        con_w[CB_NLB] = 1'b0;
                    end
                end
                TS_T6: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        con_w[CB_EU]  = 1'b1;
                        con_w[CB_NLA] = 1'b0;
                        con_w[CB_SU]  = (opcode == OP_SUB);
                    end
                end
                default: con_w = CON_IDLE;
            endcase
        end
    end

    always_comb begin
        last_state = 1'b0;
        case (t_state)
            TS_T3:   last_state = is_nop(opcode);
            TS_T4:   last_state = (opcode == OP_OUT);
            TS_T5:   last_state = (opcode == OP_LDA);
            default: last_state = 1'b0;
        endcase
    end

    assign con = con_w;
    assign hlt = hlt_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed bench for controller_sequencer, one instance per EARLY_END setting.
module tb_controller_sequencer;

    logic        CLK = 1'b0;
    logic        clr0, clr1;
    logic [3:0]  op0, op1;
    logic [11:0] con0, con1;
    logic [5:0]  ts0, ts1;
    logic        hlt0, hlt1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    controller_sequencer #(.EARLY_END(1'b0)) dut0 (
        .CLK(CLK), .CLR(clr0), .opcode(op0), .con(con0), .t_state(ts0), .hlt(hlt0)
    );

    controller_sequencer #(.EARLY_END(1'b1)) dut1 (
        .CLK(CLK), .CLR(clr1), .opcode(op1), .con(con1), .t_state(ts1), .hlt(hlt1)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        clr0 = 1'b1; clr1 = 1'b1; op0 = 4'h0; op1 = 4'h0;

        // Reset: two clocks with CLR held
        tick(); tick();
        chk("rst_t", {6'd0, ts0}, 12'h001);
        chk("rst_hlt", {11'd0, hlt0}, 12'h000);
        chk("rst_con", con0, 12'h3E3);

        // Fetch, LDA execute (op set early: must be ignored in T1..T3)
        clr0 = 1'b0; op0 = 4'hF; #1;
        chk("t1_con", con0, 12'h5E3);
        tick(); chk("t2_con", con0, 12'hBE3);
        tick(); chk("t3_con", con0, 12'h263);
        op0 = 4'h0; #1;
        tick(); chk("lda_t4", con0, 12'h1A3);
        tick(); chk("lda_t5", con0, 12'h2C3);
        tick(); chk("lda_t6", con0, 12'h3E3);
        chk("lda_t6_ts", {6'd0, ts0}, 12'h020);
        tick(); chk("lda_wrap", {6'd0, ts0}, 12'h001);

        // ADD
        op0 = 4'h1;
        tick(); tick(); tick();
        chk("add_t4", con0, 12'h1A3);
        tick(); chk("add_t5", con0, 12'h2E1);
        tick(); chk("add_t6", con0, 12'h3C7);
        tick(); chk("add_wrap", {6'd0, ts0}, 12'h001);

        // SUB
        op0 = 4'h2;
        tick(); tick(); tick(); tick(); tick();
        chk("sub_t6", con0, 12'h3CF);
        tick();

        // OUT
        op0 = 4'hE;
        tick(); tick(); tick();
        chk("out_t4", con0, 12'h3F2);
        tick(); chk("out_t5", con0, 12'h3E3);
        tick(); tick();

        // HLT: freezes at T4; con idle even if opcode changes
        op0 = 4'hF;
        tick(); tick(); tick();
        chk("hlt_t4_con", con0, 12'h3E3);
        chk("hlt_pre", {11'd0, hlt0}, 12'h000);
        tick();
        chk("hlt_set", {11'd0, hlt0}, 12'h001);
        op0 = 4'h0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hlt_hold_ts", {6'd0, ts0}, 12'h008);
            chk("hlt_hold_con", con0, 12'h3E3);
        end
        clr0 = 1'b1; #1;
        chk("hlt_clr_con", con0, 12'h3E3);
        tick();
        chk("hlt_clr_hlt", {11'd0, hlt0}, 12'h000);
        chk("hlt_clr_ts", {6'd0, ts0}, 12'h001);
        clr0 = 1'b0;

        // Reset mid-ADD at T5
        op0 = 4'h1;
        tick(); tick(); tick(); tick();
        chk("mid_t5_ts", {6'd0, ts0}, 12'h010);
        clr0 = 1'b1; #1;
        chk("mid_con", con0, 12'h3E3);
        tick();
        chk("mid_ts", {6'd0, ts0}, 12'h001);
        clr0 = 1'b0;

        // EARLY_END=1 instance
        tick(); clr1 = 1'b0; op1 = 4'h0; #1;
        tick(); tick(); tick(); tick();
        chk("ee_lda_t5", con1, 12'h2C3);
        tick(); chk("ee_lda_wrap", {6'd0, ts1}, 12'h001);
        op1 = 4'hE;
        tick(); tick(); tick();
        chk("ee_out_t4", con1, 12'h3F2);
        tick(); chk("ee_out_wrap", {6'd0, ts1}, 12'h001);
        op1 = 4'h7;
        tick(); tick();
        chk("ee_nop_t3", {6'd0, ts1}, 12'h004);
        tick(); chk("ee_nop_wrap", {6'd0, ts1}, 12'h001);
        tick();
        force dut1.u_ring.state_q = 6'b000000;
        #1;
        release dut1.u_ring.state_q;
        tick();
        chk("ee_illegal", {6'd0, ts1}, 12'h001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
